// File: rtl/board_io_pkg.sv
// board_io_pkg: shared types and cycle-count helper for the board input conditioner
package board_io_pkg;
  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } db_out_t;
  function automatic int cycles_from_us(input longint freq, input longint us);
    longint c;
    c = freq / 64'd1_000_000 * us;
    return (c < 1) ? 1 : int'(c);
  endfunction
endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: one-bit synchroniser chain, debounce counter and registered edge pulses
module debounce_cell
  import board_io_pkg::*;
#(
  parameter int DB_CYC = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    raw,
  output db_out_t q
);
  localparam int CW = $clog2(DB_CYC + 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic s, hit;
  assign s = sync[SYNC_STAGES-1];
  assign hit = (s != q.level) && (cnt == CW'(DB_CYC - 1));
  // hit implies s differs from level, so toggling the level accepts s
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      cnt  <= '0;
      q    <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      cnt  <= (s == q.level || hit) ? '0 : cnt + 1'b1;
      q    <= {q.level ^ hit, hit & s, hit & ~s};
    end
endmodule

// File: rtl/board_input_conditioner.sv
// board_input_conditioner: debounce buttons/switches into levels and pulses; BOARD_INPUT_LONG_PRESS_EN adds btn_long
module board_input_conditioner
  import board_io_pkg::*;
#(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int DEBOUNCE_US   = 10_000,
  parameter int N_BTN         = 4,
  parameter int N_SW          = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int LONG_PRESS_MS = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_SW-1:0]  sw_level,
  output logic [N_SW-1:0]  sw_change,
  output logic [N_BTN-1:0] btn_long
);
  localparam int DB_CYC = cycles_from_us(CLK_FREQ, DEBOUNCE_US);
  localparam int N = N_BTN + N_SW;
  if (SYNC_STAGES < 2 || LONG_PRESS_MS < 1) begin : g_param_check
    $error("board_input_conditioner: SYNC_STAGES must be >= 2 and LONG_PRESS_MS >= 1");
  end
  logic [1:0] rst_sync;
  logic rst_i;
  logic [N-1:0] raw;
  db_out_t db [N];
  // reset asserts asynchronously but releases on a clock edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_sync <= 2'b00;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_i = rst_sync[1];
  assign raw = {sw_raw, btn_raw};
  for (genvar i = 0; i < N; i++) begin : g_cell
    debounce_cell #(.DB_CYC(DB_CYC), .SYNC_STAGES(SYNC_STAGES)) u_cell (
      .clk,
      .rst_n(rst_i),
      .raw  (raw[i]),
      .q    (db[i])
    );
  end
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    assign {btn_level[i], btn_press[i], btn_release[i]} = db[i];
  end
  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    assign sw_level[i]  = db[N_BTN+i].level;
    assign sw_change[i] = db[N_BTN+i].rise | db[N_BTN+i].fall;
  end
`ifdef BOARD_INPUT_LONG_PRESS_EN
  localparam int LP_RAW = CLK_FREQ / 1000 * LONG_PRESS_MS;
  localparam int LP_CYC = (LP_RAW < 1) ? 1 : LP_RAW;
  localparam int HW = $clog2(LP_CYC + 1);
  for (genvar i = 0; i < N_BTN; i++) begin : g_long
    logic [HW-1:0] hold;
    logic long_q;
    // hold saturates at LP_CYC so the pulse cannot repeat until release
    always_ff @(posedge clk or negedge rst_i)
      if (!rst_i) begin
        hold   <= '0;
        long_q <= 1'b0;
      end else begin
        hold   <= btn_release[i] ? '0 : btn_press[i] ? HW'(1) :
                  (btn_level[i] && hold != HW'(LP_CYC)) ? hold + 1'b1 : hold;
        long_q <= btn_level[i] && hold == HW'(LP_CYC - 1);
      end
    assign btn_long[i] = long_q;
  end
`else
  assign btn_long = '0;
`endif
endmodule

// File: tb/tb_board_input_conditioner.sv
// tb_board_input_conditioner: table, directed and randomized checks of the debouncer
module tb_board_input_conditioner;
  localparam int DB = 16;
  localparam int LP = 1000;
`ifdef BOARD_INPUT_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] btn_raw = '0, sw_raw = '0;
  logic [3:0] btn_level, btn_press, btn_release, sw_level, sw_change, btn_long;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;

  board_input_conditioner #(
    .CLK_FREQ(1_000_000), .DEBOUNCE_US(16), .N_BTN(4), .N_SW(4),
    .SYNC_STAGES(2), .LONG_PRESS_MS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .sw_level(sw_level), .sw_change(sw_change), .btn_long(btn_long)
  );

  typedef struct {
    logic [3:0] btn, sw;
    int cyc;
    logic [3:0] lvl, prs, rel, swl, swc;
  } vec_t;
  vec_t tbl [13];

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [23:0] outs();
    return {btn_long, btn_level, btn_press, btn_release, sw_level, sw_change};
  endfunction

  logic [7:0] hist [$];
  logic [7:0] lvl, rise, fall, cur;
  logic [3:0] lng;
  logic stable;
  int press_t [4];
  int cyc, pt, lt, nl;

  initial begin
    tbl[0]  = '{4'b0001, 4'b0000, 17, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[1]  = '{4'b0001, 4'b0000,  1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    tbl[2]  = '{4'b0001, 4'b0000,  1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[3]  = '{4'b0001, 4'b1010, 17, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    tbl[4]  = '{4'b0001, 4'b1010,  1, 4'b0001, 4'b0000, 4'b0000, 4'b1010, 4'b1010};
    tbl[5]  = '{4'b0001, 4'b1010,  1, 4'b0001, 4'b0000, 4'b0000, 4'b1010, 4'b0000};
    tbl[6]  = '{4'b0000, 4'b1010, 18, 4'b0000, 4'b0000, 4'b0001, 4'b1010, 4'b0000};
    tbl[7]  = '{4'b0000, 4'b1010,  1, 4'b0000, 4'b0000, 4'b0000, 4'b1010, 4'b0000};
    tbl[8]  = '{4'b0110, 4'b0011, 18, 4'b0110, 4'b0110, 4'b0000, 4'b0011, 4'b1001};
    tbl[9]  = '{4'b0110, 4'b0011,  1, 4'b0110, 4'b0000, 4'b0000, 4'b0011, 4'b0000};
    tbl[10] = '{4'b1100, 4'b0011, 18, 4'b1100, 4'b1000, 4'b0010, 4'b0011, 4'b0000};
    tbl[11] = '{4'b0000, 4'b0000, 18, 4'b0000, 4'b0000, 4'b1100, 4'b0000, 4'b0011};
    tbl[12] = '{4'b0000, 4'b0000,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

    step(3);
    chk("reset_state", outs(), 24'h0);
    rst_n = 1'b1;
    step(5);

    for (int i = 0; i < 13; i++) begin
      btn_raw = tbl[i].btn;
      sw_raw  = tbl[i].sw;
      step(tbl[i].cyc);
      chk($sformatf("table[%0d]", i), outs(),
          {4'b0, tbl[i].lvl, tbl[i].prs, tbl[i].rel, tbl[i].swl, tbl[i].swc});
    end

    for (int t = 0; t < 20; t++) begin
      btn_raw[1] = ~btn_raw[1];
      repeat (5) begin
        step(1);
        chk("t2_bounce", outs(), 24'h0);
      end
    end
    btn_raw[1] = 1'b1;
    repeat (17) begin
      step(1);
      chk("t2_settle", outs(), 24'h0);
    end
    step(1);
    chk("t2_press", outs(), {4'b0, 4'b0010, 4'b0010, 4'b0, 4'b0, 4'b0});
    btn_raw[1] = 1'b0;
    step(18);
    chk("t2_release", outs(), {4'b0, 4'b0, 4'b0, 4'b0010, 4'b0, 4'b0});
    step(2);

    btn_raw[3] = 1'b1;
    repeat (15) begin
      step(1);
      chk("t5_short_hold", outs(), 24'h0);
    end
    btn_raw[3] = 1'b0;
    repeat (40) begin
      step(1);
      chk("t5_after", outs(), 24'h0);
    end

    btn_raw[0] = 1'b1;
    pt = -1; lt = -1; nl = 0;
    for (int n = 1; n <= 1230; n++) begin
      if (n == 1201) btn_raw[0] = 1'b0;
      step(1);
      if (btn_press[0]) pt = n;
      if (btn_long != 4'b0) begin
        nl++;
        lt = n;
      end
    end
    chk("t6_press_at", pt, 18);
    chk("t6_long_count", nl, LONG_EN ? 1 : 0);
    chk("t6_long_at", lt, LONG_EN ? 18 + LP : -1);
    chk("t6_idle", outs(), 24'h0);

    sw_raw = 4'b1010;
    step(18);
    chk("t4_sw_pre", outs(), {4'b0, 4'b0, 4'b0, 4'b0, 4'b1010, 4'b1010});
    step(1);
    btn_raw = 4'b0100;
    step(12);
    chk("t4_midcount", outs(), {4'b0, 4'b0, 4'b0, 4'b0, 4'b1010, 4'b0});
    rst_n = 1'b0;
    #1;
    chk("t4_async_clear", outs(), 24'h0);
    step(3);
    rst_n = 1'b1;
    step(19);
    chk("t4_not_yet", outs(), 24'h0);
    step(1);
    chk("t4_accept", outs(), {4'b0, 4'b0100, 4'b0100, 4'b0, 4'b1010, 4'b1010});
    step(1);
    chk("t4_pulse_end", outs(), {4'b0, 4'b0100, 4'b0, 4'b0, 4'b1010, 4'b0});

    rst_n = 1'b0;
    btn_raw = '0;
    sw_raw = '0;
    step(3);
    rst_n = 1'b1;
    step(5);
    hist.delete();
    for (int i = 0; i < 18; i++) hist.push_back(8'h0);
    lvl = '0;
    for (int b = 0; b < 4; b++) press_t[b] = -100000;
    cyc = 0;
    cur = '0;
    repeat (3000) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(23) == 0) cur[b] = ~cur[b];
      {sw_raw, btn_raw} = cur;
      step(1);
      cyc++;
      hist.push_back(cur);
      void'(hist.pop_front());
      rise = '0; fall = '0; lng = '0;
      for (int b = 0; b < 8; b++) begin
        stable = 1'b1;
        for (int j = 2; j < 2 + DB; j++)
          if (hist[hist.size() - 1 - j][b] == lvl[b]) stable = 1'b0;
        if (stable) begin
          rise[b] = ~lvl[b];
          fall[b] = lvl[b];
          lvl[b]  = ~lvl[b];
        end
      end
      for (int b = 0; b < 4; b++) begin
        if (rise[b]) press_t[b] = cyc;
        if (LONG_EN && lvl[b] && cyc == press_t[b] + LP) lng[b] = 1'b1;
      end
      chk("random", outs(),
          {lng, lvl[3:0], rise[3:0], fall[3:0], lvl[7:4], rise[7:4] | fall[7:4]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
